tube_target_port: RTL and testbench

//  Target (responder) end of the 8-bit Tube register bus (tube_cs_n/rd_n/wr_n, 3-bit adr).

---
 rtl/tube_pkg.sv | 35 +++
 rtl/tube_sync_fifo.sv | 70 +++++++
 rtl/tube_target_port.sv | 179 +++++++++++++++++
 tb/tb_tube_target_port.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
// Shared types and constants for the Tube target port.
//  TUBE_ADR_W / TUBE_DAT_W : register-bus address and data widths
//  tube_wr_entry_t         : one queued write {adr, dat}
//  tube_det_e              : per-strobe edge-detector state
//  tube_det_next()         : next state of an edge detector given the sampled strobe level
package tube_pkg;

    localparam int TUBE_ADR_W   = 3;
    localparam int TUBE_DAT_W   = 8;
    localparam int TUBE_NREG    = 1 << TUBE_ADR_W;
    localparam int TUBE_ENTRY_W = TUBE_ADR_W + TUBE_DAT_W;

    typedef struct packed {
        logic [TUBE_ADR_W-1:0] adr;
        logic [TUBE_DAT_W-1:0] dat;
    } tube_wr_entry_t;

    // DISARMED is the post-reset state: a strobe that is already low must be
    // seen high once before its falling edge can count.
    typedef enum logic [1:0] {
        DET_DISARMED = 2'd0,
        DET_IDLE     = 2'd1,
        DET_ACTIVE   = 2'd2
    } tube_det_e;

    function automatic tube_det_e tube_det_next(input tube_det_e st, input logic low);
        tube_det_e nxt;
        case (st)
            DET_IDLE, DET_ACTIVE: nxt = low ? DET_ACTIVE : DET_IDLE;
            default:              nxt = low ? DET_DISARMED : DET_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tube_sync_fifo.sv
// Small synchronous FIFO carrying Tube write entries to the internal consumer.
//  clk, reset     : clock, synchronous active-high reset
//  push_i         : enqueue push_dat_i (accepted when not full, or full with a pop this cycle)
//  push_dat_i     : entry to enqueue
//  pop_i          : dequeue head (ignored when empty)
//  head_o         : head entry, read straight from the storage registers
//  valid_o        : FIFO holds at least one entry
//  full_o         : FIFO holds DEPTH entries
module tube_sync_fifo
    import tube_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = TUBE_ENTRY_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         valid_o,
    output logic         full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i & valid_o;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push  = push_i & (~full_o | do_pop);
        // DEPTH is a power of two, so pointer wrap is plain binary overflow.
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: nothing is visible until cnt_q says so.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/tube_target_port.sv
// Target end of the 8-bit Tube register bus.
//  clk, reset                 : clock, synchronous active-high reset
//  tube_adr/cs_n/rd_n/wr_n    : initiator address and active-low strobes
//  tube_dat                   : bidirectional data; driven only while a read strobe is low
//  wr_valid/wr_ready          : write-FIFO head handshake to the internal consumer
//  wr_adr/wr_dat              : write-FIFO head entry
//  rd_load/_adr/_dat          : internal load of the 8-entry read register file
//  rd_event/rd_event_adr      : one-cycle pulse per recognised read access, with its address
//  overflow/ovf_clr           : sticky write-dropped flag and its clear
//  proto_err                  : one-cycle pulse when cs, rd and wr are low together
module tube_target_port
    import tube_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [TUBE_ADR_W-1:0] tube_adr,
    inout  wire  [TUBE_DAT_W-1:0] tube_dat,
    input  logic                  tube_cs_n,
    input  logic                  tube_rd_n,
    input  logic                  tube_wr_n,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [TUBE_ADR_W-1:0] wr_adr,
    output logic [TUBE_DAT_W-1:0] wr_dat,
    input  logic                  rd_load,
    input  logic [TUBE_ADR_W-1:0] rd_load_adr,
    input  logic [TUBE_DAT_W-1:0] rd_load_dat,
    output logic                  rd_event,
    output logic [TUBE_ADR_W-1:0] rd_event_adr,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic                  proto_err
);

    // ---------------------------------------------------------------
    // Read register file and combinational read drive
    // ---------------------------------------------------------------
    logic [TUBE_DAT_W-1:0] rdreg_q [TUBE_NREG];
    logic                  rd_drive;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TUBE_NREG; i++) rdreg_q[i] <= '0;
        end else if (rd_load) begin
            rdreg_q[rd_load_adr] <= rd_load_dat;
        end
    end

    // Driven from the raw pins so a one-cycle strobe from a same-clock
    // initiator sees its data; a load this cycle lands only after the edge.
    assign rd_drive = ~tube_cs_n & ~tube_rd_n & tube_wr_n;
    assign tube_dat = rd_drive ? rdreg_q[tube_adr] : {TUBE_DAT_W{1'bz}};

    // ---------------------------------------------------------------
    // Input synchroniser: strobes, address and data travel together
    // ---------------------------------------------------------------
    localparam int SW = 3 + TUBE_ADR_W + TUBE_DAT_W;

    logic [SW-1:0]         pin_vec, syn_vec;
    logic                  s_cs_n, s_rd_n, s_wr_n;
    logic [TUBE_ADR_W-1:0] s_adr;
    logic [TUBE_DAT_W-1:0] s_dat;

    assign pin_vec = {tube_cs_n, tube_rd_n, tube_wr_n, tube_adr, tube_dat};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign syn_vec = pin_vec;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
            // Not reset: the chain keeps tracking the pins through reset so a
            // strobe held low across release is seen low, not as a fresh edge.
            always_ff @(posedge clk) begin
                sync_q[0] <= pin_vec;
                for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
            assign syn_vec = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign s_cs_n = syn_vec[SW-1];
    assign s_rd_n = syn_vec[SW-2];
    assign s_wr_n = syn_vec[SW-3];
    assign s_adr  = syn_vec[TUBE_DAT_W +: TUBE_ADR_W];
    assign s_dat  = syn_vec[TUBE_DAT_W-1:0];

    // ---------------------------------------------------------------
    // Access detection: one edge detector per strobe term
    // ---------------------------------------------------------------
    tube_det_e rd_st_q, rd_st_d;
    tube_det_e wr_st_q, wr_st_d;
    logic      rd_term, wr_term;
    logic      rd_fall, wr_fall;
    logic      rd_access, wr_access, proto_hit;

    assign rd_term = ~s_cs_n & ~s_rd_n;
    assign wr_term = ~s_cs_n & ~s_wr_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_st_q <= DET_DISARMED;
            wr_st_q <= DET_DISARMED;
        end else begin
            rd_st_q <= rd_st_d;
            wr_st_q <= wr_st_d;
        end
    end

    always_comb begin
        rd_st_d   = tube_det_next(rd_st_q, rd_term);
        wr_st_d   = tube_det_next(wr_st_q, wr_term);
        rd_fall   = (rd_st_q == DET_IDLE) & rd_term;
        wr_fall   = (wr_st_q == DET_IDLE) & wr_term;
        // Either term starting while the other is also low is an illegal
        // cycle: flag it and suppress both the read event and the push.
        proto_hit = (rd_fall | wr_fall) & rd_term & wr_term;
        rd_access = rd_fall & ~wr_term;
        wr_access = wr_fall & ~rd_term;
    end

    // ---------------------------------------------------------------
    // Write FIFO
    // ---------------------------------------------------------------
    tube_wr_entry_t push_ent, head_ent;
    logic           fifo_full, fifo_pop;

    assign push_ent = '{adr: s_adr, dat: s_dat};
    assign fifo_pop = wr_valid & wr_ready;

    tube_sync_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(tube_wr_entry_t))
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (wr_access),
        .push_dat_i (push_ent),
        .pop_i      (fifo_pop),
        .head_o     (head_ent),
        .valid_o    (wr_valid),
        .full_o     (fifo_full)
    );

    assign wr_adr = head_ent.adr;
    assign wr_dat = head_ent.dat;

    // ---------------------------------------------------------------
    // Registered event / status outputs
    // ---------------------------------------------------------------
    logic                  rd_event_q, proto_err_q, overflow_q, overflow_d;
    logic [TUBE_ADR_W-1:0] rd_event_adr_q;

    // Set beats clear so a drop in the clearing cycle is never lost.
    assign overflow_d = (wr_access & fifo_full & ~fifo_pop) ? 1'b1 :
                        ovf_clr                             ? 1'b0 : overflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_event_q     <= 1'b0;
            rd_event_adr_q <= '0;
            proto_err_q    <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            rd_event_q  <= rd_access;
            proto_err_q <= proto_hit;
            overflow_q  <= overflow_d;
            if (rd_access) rd_event_adr_q <= s_adr;
        end
    end

    assign rd_event     = rd_event_q;
    assign rd_event_adr = rd_event_adr_q;
    assign proto_err    = proto_err_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_tube_target_port.sv
module tb_tube_target_port;

    localparam int SS    = 0;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] tube_adr;
    wire  [7:0] tube_dat;
    logic       tube_cs_n, tube_rd_n, tube_wr_n;
    logic       wr_valid, wr_ready;
    logic [2:0] wr_adr;
    logic [7:0] wr_dat;
    logic       rd_load;
    logic [2:0] rd_load_adr;
    logic [7:0] rd_load_dat;
    logic       rd_event;
    logic [2:0] rd_event_adr;
    logic       overflow, ovf_clr, proto_err;

    logic       tb_drv;
    logic [7:0] tb_dat;
    assign tube_dat = tb_drv ? tb_dat : 8'hzz;

    tube_target_port #(.SYNC_STAGES(SS), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .tube_adr     (tube_adr),
        .tube_dat     (tube_dat),
        .tube_cs_n    (tube_cs_n),
        .tube_rd_n    (tube_rd_n),
        .tube_wr_n    (tube_wr_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_adr       (wr_adr),
        .wr_dat       (wr_dat),
        .rd_load      (rd_load),
        .rd_load_adr  (rd_load_adr),
        .rd_load_dat  (rd_load_dat),
        .rd_event     (rd_event),
        .rd_event_adr (rd_event_adr),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: register file, FIFO as a queue, sticky flag, and
    // whether each strobe term was already low on the previous sampled cycle.
    logic [10:0] q[$];
    logic [7:0]  m_reg[8];
    logic        m_ovf;
    logic        m_rd_blk, m_wr_blk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called #1 after a posedge: drive one cycle of pins, check the bus mid-cycle,
    // clock, then check registered outputs against the model.
    task automatic step(input logic cs_n, input logic rd_n, input logic wr_n,
                        input logic [2:0] a, input logic [7:0] d, input logic rdy,
                        input logic ld, input logic [2:0] la, input logic [7:0] ldd,
                        input logic clr);
        logic rd_t, wr_t, rd_f, wr_f, e_rd, e_push, e_pe, pop, set;
        tube_cs_n = cs_n; tube_rd_n = rd_n; tube_wr_n = wr_n;
        tube_adr = a; tb_dat = d;
        tb_drv = !(!cs_n && !rd_n && wr_n);
        wr_ready = rdy; rd_load = ld; rd_load_adr = la; rd_load_dat = ldd; ovf_clr = clr;
        #2;
        if (!tb_drv) chk("bus_read", 16'(tube_dat), 16'(m_reg[a]));
        else         chk("bus_released", 16'(tube_dat), 16'(d));
        rd_t = !cs_n && !rd_n;
        wr_t = !cs_n && !wr_n;
        rd_f = rd_t && !m_rd_blk;
        wr_f = wr_t && !m_wr_blk;
        m_rd_blk = rd_t;
        m_wr_blk = wr_t;
        e_pe   = (rd_f || wr_f) && rd_t && wr_t;
        e_rd   = rd_f && !wr_t;
        e_push = wr_f && !rd_t;
        pop    = (q.size() != 0) && rdy;
        @(posedge clk); #1;
        if (pop) void'(q.pop_front());
        set = 1'b0;
        if (e_push) begin
            if (q.size() < DEPTH) q.push_back({a, d});
            else set = 1'b1;
        end
        m_ovf = set ? 1'b1 : (clr ? 1'b0 : m_ovf);
        if (ld) m_reg[la] = ldd;
        chk("rd_event", 16'(rd_event), 16'(e_rd));
        if (e_rd) chk("rd_event_adr", 16'(rd_event_adr), 16'(a));
        chk("proto_err", 16'(proto_err), 16'(e_pe));
        chk("wr_valid", 16'(wr_valid), 16'(q.size() != 0));
        if (q.size() != 0) chk("wr_head", 16'({wr_adr, wr_dat}), 16'(q[0]));
        chk("overflow", 16'(overflow), 16'(m_ovf));
    endtask

    task automatic rst_cycles(input int n, input logic cs_n, input logic rd_n,
                              input logic wr_n, input logic [2:0] a, input logic [7:0] d);
        reset = 1'b1;
        tube_cs_n = cs_n; tube_rd_n = rd_n; tube_wr_n = wr_n; tube_adr = a;
        tb_dat = d; tb_drv = 1'b1;
        wr_ready = 1'b0; rd_load = 1'b0; rd_load_adr = 3'd0; rd_load_dat = 8'd0; ovf_clr = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
        chk("rst_wr_valid", 16'(wr_valid), 16'(0));
        chk("rst_rd_event", 16'(rd_event), 16'(0));
        chk("rst_overflow", 16'(overflow), 16'(0));
        chk("rst_proto_err", 16'(proto_err), 16'(0));
        q.delete();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_ovf = 1'b0;
        m_rd_blk = 1'b1;
        m_wr_blk = 1'b1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) step(1'b1, 1'b1, 1'b1, 3'd0, 8'($urandom_range(0, 255)), rdy,
                        1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    task automatic load(input logic [2:0] a, input logic [7:0] d);
        step(1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 1'b1, a, d, 1'b0);
    endtask

    task automatic rd_strobe(input logic [2:0] a, input int len);
        repeat (len) step(1'b0, 1'b0, 1'b1, a, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    task automatic wr_strobe(input logic [2:0] a, input logic [7:0] d, input int len,
                             input logic rdy, input logic clr);
        repeat (len) step(1'b0, 1'b1, 1'b0, a, d, rdy, 1'b0, 3'd0, 8'h00, clr);
    endtask

    initial begin
        int         k, len;
        logic       rn, wn;
        logic [2:0] a;
        logic [7:0] d;

        rst_cycles(3, 1'b1, 1'b1, 1'b1, 3'd0, 8'h00);

        // Register file comes out of reset as zero.
        rd_strobe(3'd3, 1);
        idle(1, 1'b0);

        // One-cycle read of a loaded register; event next cycle, bus released after.
        load(3'd5, 8'hA5);
        load(3'd1, 8'h11);
        rd_strobe(3'd5, 1);
        idle(2, 1'b0);

        // Long write strobe yields exactly one entry.
        wr_strobe(3'd2, 8'h3C, 4, 1'b0, 1'b0);
        idle(1, 1'b0);
        idle(2, 1'b1);

        // Five writes into a 4-deep FIFO with the consumer stalled.
        for (int i = 0; i < 5; i++) begin
            wr_strobe(3'(i), 8'(8'h40 + i), 1, 1'b0, 1'b0);
            idle(1, 1'b0);
        end
        idle(1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        // Drop and clear in the same cycle: the drop wins.
        wr_strobe(3'd7, 8'hEE, 1, 1'b0, 1'b1);
        idle(1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);

        // Full FIFO, write with a simultaneous pop: accepted, no overflow.
        wr_strobe(3'd6, 8'h5E, 1, 1'b1, 1'b0);
        idle(1, 1'b0);
        idle(5, 1'b1);

        // Load and read of the same register in one cycle returns the old value.
        step(1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 1'b1, 3'd1, 8'h77, 1'b0);
        idle(1, 1'b0);
        rd_strobe(3'd1, 2);
        idle(1, 1'b0);

        // cs, rd and wr all low together.
        step(1'b0, 1'b0, 1'b0, 3'd4, 8'h99, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 3'd4, 8'h99, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        idle(1, 1'b0);

        // Reset in the middle of a write strobe, released with the strobe still low.
        wr_strobe(3'd6, 8'h99, 2, 1'b0, 1'b0);
        rst_cycles(3, 1'b0, 1'b1, 1'b0, 3'd6, 8'h99);
        wr_strobe(3'd6, 8'h99, 2, 1'b0, 1'b0);
        idle(1, 1'b0);
        wr_strobe(3'd7, 8'h42, 2, 1'b0, 1'b0);
        idle(2, 1'b1);

        // Randomised traffic against the model.
        for (int t = 0; t < 200; t++) begin
            k   = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, 4));
            a   = 3'($urandom_range(0, 7));
            d   = 8'($urandom_range(0, 255));
            rn  = !(k < 5 || k == 9);
            wn  = !(k >= 5);
            for (int c = 0; c < len; c++)
                step(1'b0, rn, wn, a, d, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                     8'($urandom_range(0, 255)), ($urandom_range(0, 9) == 0));
            for (int g = int'($urandom_range(0, 2)); g > 0; g--)
                step(1'b1, 1'b1, 1'b1, 3'd0, 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                     3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                     ($urandom_range(0, 9) == 0));
        end
        idle(6, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
